// File: rtl/uart_rx_pkg.sv
// Shared types and timing constants for the UART receive sampler.
// Build option UART_RX_MAJORITY_VOTE_EN is consumed by uart_rx_sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_W        = $clog2(TICKS_PER_BIT);

    localparam logic [TICK_W-1:0] SAMPLE_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] BIT_END_TICK = TICK_W'(15);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: 16x oversampled 7/8-bit LSB-first frames, optional parity, sticky status flags.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 3-sample majority (cnt 6,7,8).
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low on a tick
// START  | validating start bit at its centre
// DATA   | shifting in data bits LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; frame completes at the decision tick
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_strobe,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    rx_state_t         state, state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic              par_mismatch;
    logic              rx_s;
    logic              sample;
    logic              decide;
    logic              bit_end;
    logic              last_bit;
    logic              frame_done;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s6_q, s7_q;

    // Earlier two votes are held so the decision can be made on the cnt==8 tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else if (baud_clock) begin
            if (tick_cnt == SAMPLE_TICK - TICK_W'(1)) s6_q <= rx_s;
            if (tick_cnt == SAMPLE_TICK)              s7_q <= rx_s;
        end
    end

    assign decide = baud_clock && (tick_cnt == SAMPLE_TICK + TICK_W'(1));
    assign sample = majority3(s6_q, s7_q, rx_s);
`else
    assign decide = baud_clock && (tick_cnt == SAMPLE_TICK);
    assign sample = rx_s;
`endif

    assign bit_end  = baud_clock && (tick_cnt == BIT_END_TICK);
    assign last_bit = (bit_cnt == (bit8 ? 3'd7 : 3'd6));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (baud_clock && !rx_s) state_next = START;
            START: begin
                if (decide && sample) state_next = IDLE;
                else if (bit_end)     state_next = DATA;
            end
            DATA:    if (bit_end && last_bit) state_next = parity_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP: begin
                if (decide) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            par_mismatch <= 1'b0;
        end else if (baud_clock) begin
            tick_cnt <= (state == IDLE || state_next == IDLE) ? '0 : tick_cnt + TICK_W'(1);
            if (state == IDLE && state_next == START) begin
                bit_cnt      <= '0;
                shift_q      <= '0;
                par_mismatch <= 1'b0;
            end
            if (state == DATA && decide)  shift_q[bit_cnt] <= sample;
            if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
            if (state == PARITY && decide) par_mismatch <= sample ^ (^shift_q) ^ odd_n_even;
        end
    end

    // A read landing on the completion clock clears the old flags but the new byte still wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            data_ready  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else if (frame_done) begin
            rx_data     <= shift_q;
            data_ready  <= 1'b1;
            framing_err <= (framing_err & ~read_strobe) | ~sample;
            parity_err  <= (parity_err & ~read_strobe) | par_mismatch;
            overflow    <= (overflow & ~read_strobe) | (data_ready & ~read_strobe);
        end else if (read_strobe) begin
            data_ready  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end
    end

endmodule
